// File: rtl/siphash_sched.sv
// siphash_sched: round-robin scheduler sharing one siphash core among N_REQ requesters.
// Latency: accept in cycle T, core_start in T+1; rsp_valid rises the cycle after core_done.
// Backpressure: rsp_valid/rsp_result hold until rsp_ready[g]; no new accept before that handshake.
// Build option: define SIPHASH_SCHED_TIMEOUT_EN to bound WAIT by TIMEOUT_CYCLES (rsp_err=1 on expiry).
module siphash_sched #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*64-1:0]   req_nonce,
  input  logic [255:0]          key,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [63:0]           rsp_result,
  output logic                  rsp_err,
  output logic                  core_start,
  output logic [255:0]          core_key,
  output logic [63:0]           core_nonce,
  input  logic                  core_done,
  input  logic [63:0]           core_result,
  output logic                  sched_busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CW    = IDX_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_q;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] cand_idx;
  logic [CW-1:0]    cand_sum;
  logic             gnt_any;
  logic             accept;
  logic             tmo_hit;
  logic [255:0]     key_q;
  logic [63:0]      nonce_q;
  logic [63:0]      nonce_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_nonce
    assign nonce_arr[i] = req_nonce[64*i +: 64];
  end

  assign core_key   = key_q;
  assign core_nonce = nonce_q;
  assign accept     = (state_q == ST_IDLE) && gnt_any && !rst;

  // Round-robin search from rr_ptr+1 upward with wrap; the nearest valid requester wins.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand_sum = '0;
    cand_idx = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand_sum = {1'b0, rr_ptr} + CW'(i);
      if (cand_sum >= CW'(N_REQ)) begin
        cand_sum = cand_sum - CW'(N_REQ);
      end
      cand_idx = cand_sum[IDX_W-1:0];
      if (req_valid[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

`ifdef SIPHASH_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Expiry only counts when the core has not answered in the same cycle: a late done still wins.
  assign tmo_hit = (state_q == ST_WAIT) && !core_done && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // WAIT-cycle counter: cleared during ISSUE so it starts at zero on WAIT entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state_q == ST_ISSUE) begin
      tmo_cnt <= '0;
    end else if (state_q == ST_WAIT && !core_done) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Error flag: set on expiry, cleared by a real completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err <= 1'b0;
    end else if (state_q == ST_WAIT) begin
      if (core_done) begin
        rsp_err <= 1'b0;
      end else if (tmo_hit) begin
        rsp_err <= 1'b1;
      end
    end
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
  assign tmo_hit        = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-state strobes; req_ready is masked during reset so no accept is signalled.
  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    rsp_valid  = '0;
    core_start = 1'b0;
    sched_busy = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_ready = N_REQ'(1) << gnt_idx;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        core_start = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done || tmo_hit) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = N_REQ'(1) << gnt_q;
        if (rsp_ready[gnt_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Job capture at accept, result capture in WAIT, pointer update on the response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= IDX_W'(N_REQ - 1);
      gnt_q      <= '0;
      key_q      <= '0;
      nonce_q    <= '0;
      rsp_result <= '0;
    end else begin
      if (accept) begin
        gnt_q   <= gnt_idx;
        key_q   <= key;
        nonce_q <= nonce_arr[gnt_idx];
      end
      if (state_q == ST_WAIT) begin
        if (core_done) begin
          rsp_result <= core_result;
        end else if (tmo_hit) begin
          rsp_result <= '0;
        end
      end
      if (state_q == ST_RESP && rsp_ready[gnt_q]) begin
        rr_ptr <= gnt_q;
      end
    end
  end

endmodule

// File: tb/tb_siphash_sched.sv
// tb_siphash_sched: randomized and directed bench for siphash_sched with a job-level reference model.
// Latency: the model predicts every output cycle by cycle from accepts, core completions and handshakes.
// Backpressure: rsp_ready is held low, toggled on foreign bits and randomized to exercise RESP hold.
`timescale 1ns/1ps
module tb_siphash_sched;

  localparam int N  = 4;
  localparam int TO = 16;
`ifdef SIPHASH_SCHED_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*64-1:0] req_nonce;
  logic [255:0]    key;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [63:0]     rsp_result;
  logic            rsp_err;
  logic            core_start;
  logic [255:0]    core_key;
  logic [63:0]     core_nonce;
  logic            core_done;
  logic [63:0]     core_result;
  logic            sched_busy;

  siphash_sched #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_nonce(req_nonce), .key(key), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .core_start(core_start),
    .core_key(core_key), .core_nonce(core_nonce), .core_done(core_done),
    .core_result(core_result), .sched_busy(sched_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- helpers ----------------
  function automatic logic [63:0] fmix(input logic [255:0] k, input logic [63:0] n);
    return ((k[63:0] ^ k[191:128]) + {n[31:0], n[63:32]}) ^ (k[127:64] - k[255:192]);
  endfunction

  function automatic bit bit_at(input logic [N-1:0] v, input int j);
    logic [N-1:0] s;
    s = v >> j;
    return s[0];
  endfunction

  function automatic logic [N-1:0] onehot(input int j);
    return N'(1) << j;
  endfunction

  // Grant = first set request after the last served requester, wrapping around.
  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (bit_at(v, (last + k) % N)) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int oh2idx(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (bit_at(v, k)) return k;
    return -1;
  endfunction

  function automatic logic [63:0] nonce_of(input logic [N*64-1:0] all, input int j);
    logic [N*64-1:0] s;
    s = all >> (64 * j);
    return s[63:0];
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- cycle counter ----------------
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- core model + job-level reference model ----------------
  int  cd_cnt    = 0;
  bit  core_en   = 1'b1;
  int  core_lat  = 20;
  bit  glitch_en = 1'b0;
  bit  spur_done = 1'b0;
  int  n_starts  = 0;
  int  n_jobs    = 0;
  int  start_cyc = 0;
  int  obs_grants[$];

  bit           m_busy, m_start, m_wait, m_rsp, e_err;
  int           m_last, e_g, w_cnt;
  logic [255:0] e_key;
  logic [63:0]  e_nonce, e_res;

  initial begin
    int g;
    logic [N-1:0] exp_rdy;
    core_done   = 1'b0;
    core_result = '0;
    m_busy = 0; m_start = 0; m_wait = 0; m_rsp = 0; e_err = 0;
    m_last = N - 1; e_g = 0; w_cnt = 0; e_key = '0; e_nonce = '0; e_res = '0;
    forever begin
      @(negedge clk);
      // core: done pulse lat cycles after start, result computed from what the core is given
      core_done = 1'b0;
      if (cd_cnt > 0) begin
        cd_cnt--;
        if (cd_cnt == 0) begin
          core_done   = 1'b1;
          core_result = fmix(core_key, core_nonce);
        end
      end
      if (spur_done && !sched_busy) begin
        core_done   = 1'b1;
        core_result = {$urandom, $urandom};
        spur_done   = 1'b0;
      end
      if (core_start) begin
        n_starts++;
        start_cyc = cyc;
        if (core_en) cd_cnt = (core_lat > 0) ? core_lat : int'($urandom_range(1, 12));
        if (glitch_en && $urandom_range(0, 3) == 0) begin
          core_done   = 1'b1;
          core_result = {$urandom, $urandom};
        end
      end
      if (rst) begin
        check_eq("rst_req_ready", req_ready, '0);
        m_busy = 0; m_start = 0; m_wait = 0; m_rsp = 0; m_last = N - 1;
      end else begin
        g       = -1;
        exp_rdy = '0;
        if (!m_busy) begin
          g = pick(req_valid, m_last);
          if (g >= 0) exp_rdy = onehot(g);
        end
        check_eq("req_ready", req_ready, exp_rdy);
        check_eq("sched_busy", sched_busy, m_busy);
        check_eq("core_start", core_start, m_start);
        if (m_start || m_wait) check_eq("core_key_nonce", {core_key, core_nonce}, {e_key, e_nonce});
        check_eq("rsp_valid", rsp_valid, m_rsp ? onehot(e_g) : '0);
        if (m_rsp) check_eq("rsp_err_result", {rsp_err, rsp_result}, {e_err, e_res});
        if (req_ready != '0) obs_grants.push_back(oh2idx(req_ready));
        // advance model to the next cycle
        if (m_rsp) begin
          if (bit_at(rsp_ready, e_g)) begin
            m_rsp = 0; m_busy = 0; m_last = e_g; n_jobs++;
          end
        end else if (m_wait) begin
          if (core_done) begin
            m_wait = 0; m_rsp = 1; e_err = 0; e_res = fmix(e_key, e_nonce);
          end else begin
            w_cnt++;
            if (TMO_ON && w_cnt == TO) begin
              m_wait = 0; m_rsp = 1; e_err = 1; e_res = '0;
            end
          end
        end
        if (m_start) begin
          m_start = 0; m_wait = 1; w_cnt = 0;
        end
        if (g >= 0) begin
          m_busy = 1; m_start = 1; e_g = g; e_key = key; e_nonce = nonce_of(req_nonce, g);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string tag, input int lim);
    int k;
    k = 0;
    @(negedge clk);
    while (req_ready == '0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, k < lim, 1'b1);
  endtask

  task automatic wait_rsp(input string tag, input int lim);
    int k;
    k = 0;
    @(negedge clk);
    while (rsp_valid == '0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, k < lim, 1'b1);
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int k;
    k = 0;
    @(negedge clk);
    while (sched_busy && k < lim) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, k < lim, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random tests ----------------
  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    logic [255:0] k_sv;
    logic [63:0]  n_sv, r_sv;
    int t_acc, s0, j0;
    rst = 1'b1; req_valid = '0; req_nonce = '0; key = '0; rsp_ready = '0;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_outputs", {req_ready, rsp_valid, rsp_err, core_start, sched_busy,
             rsp_result, core_key, core_nonce}, '0);

    // 1: single job on requester 0, core answers 20 cycles after start
    @(posedge clk); #1;
    k_sv = rnd256();
    key = k_sv; req_nonce = '0; req_nonce[63:0] = 64'h1; req_valid = 4'b0001; core_lat = 20;
    wait_accept("t1_accept_timeout", 50);
    t_acc = cyc;
    check_eq("t1_req_ready", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp("t1_rsp_timeout", 100);
    check_eq("t1_start_latency", start_cyc - t_acc, 1);
    check_eq("t1_rsp_latency", cyc - start_cyc, 21);
    check_eq("t1_rsp_valid", rsp_valid, 4'b0001);
    check_eq("t1_rsp_result", rsp_result, fmix(k_sv, 64'h1));
    @(posedge clk); #1;
    rsp_ready = 4'b0001;
    tick(1);
    rsp_ready = '0;

    // 2: round-robin with all requesters held and responses always accepted
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    obs_grants.delete();
    s0 = n_starts;
    core_lat = 0;
    req_valid = 4'b1111; rsp_ready = 4'b1111; key = rnd256();
    for (int i = 0; i < N; i++) req_nonce[64*i +: 64] = {$urandom, $urandom};
    for (int k = 0; k < 600 && obs_grants.size() < 5; k++) @(posedge clk);
    #1;
    req_valid = '0;
    wait_idle("t2_idle_timeout", 100);
    check_eq("t2_grant_count", obs_grants.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < obs_grants.size()) check_eq($sformatf("t2_grant%0d", i), obs_grants[i], rr_exp[i]);
    end
    check_eq("t2_starts_per_job", n_starts - s0, obs_grants.size());

    // 3: key and nonce change right after accept must not disturb the job
    @(posedge clk); #1;
    rsp_ready = '0;
    k_sv = rnd256(); n_sv = {$urandom, $urandom};
    key = k_sv; req_nonce[128 +: 64] = n_sv; req_valid = 4'b0100; core_lat = 9;
    wait_accept("t3_accept_timeout", 50);
    @(posedge clk); #1;
    key = rnd256(); req_nonce[128 +: 64] = {$urandom, $urandom}; req_valid = '0;
    wait_rsp("t3_rsp_timeout", 100);
    check_eq("t3_core_key_nonce", {core_key, core_nonce}, {k_sv, n_sv});
    check_eq("t3_rsp_result", rsp_result, fmix(k_sv, n_sv));

    // 4: response backpressure for 10 cycles with other requesters waiting
    @(posedge clk); #1;
    rsp_ready = 4'b0100;
    tick(1);
    rsp_ready = '0; req_valid = 4'b0010; core_lat = 5;
    wait_accept("t4_accept_timeout", 50);
    @(posedge clk); #1;
    req_valid = 4'b1011;
    wait_rsp("t4_rsp_timeout", 100);
    r_sv = rsp_result;
    @(posedge clk); #1;
    rsp_ready = 4'b1101;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("t4_hold_valid", rsp_valid, 4'b0010);
      check_eq("t4_hold_result", rsp_result, r_sv);
      check_eq("t4_no_accept", req_ready, '0);
    end
    @(posedge clk); #1;
    rsp_ready = 4'b1111;
    tick(1);
    req_valid = '0;
    wait_idle("t4_idle_timeout", 200);

    // 5: reset in the middle of WAIT drops the job
    @(posedge clk); #1;
    rsp_ready = '0; req_valid = 4'b0100; core_lat = 30;
    wait_accept("t5_accept_timeout", 50);
    @(posedge clk); #1;
    req_valid = '0;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("t5_outputs_zero", {req_ready, rsp_valid, rsp_err, core_start, sched_busy,
             rsp_result, core_key, core_nonce}, '0);
    tick(40);
    @(posedge clk); #1;
    req_valid = 4'b1111; core_lat = 3;
    wait_accept("t5_accept2_timeout", 50);
    check_eq("t5_first_grant", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0; rsp_ready = 4'b1111;
    wait_idle("t5_idle_timeout", 100);

`ifdef SIPHASH_SCHED_TIMEOUT_EN
    // 6: core never answers; WAIT expires after TO cycles
    @(posedge clk); #1;
    rsp_ready = '0; core_en = 1'b0; req_valid = 4'b0001;
    wait_accept("t6_accept_timeout", 50);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp("t6_rsp_timeout", 200);
    check_eq("t6_rsp_latency", cyc - start_cyc, TO + 1);
    check_eq("t6_err_result", {rsp_err, rsp_result}, {1'b1, 64'h0});
    @(posedge clk); #1;
    rsp_ready = 4'b0001;
    tick(1);
    rsp_ready = '0; core_en = 1'b1;
`endif

    // 7: randomized traffic, random latencies, spurious dones in IDLE/ISSUE
    core_lat = 0; glitch_en = 1'b1;
    j0 = n_jobs;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      req_valid = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      key = rnd256();
      for (int i = 0; i < N; i++) req_nonce[64*i +: 64] = {$urandom, $urandom};
      rsp_ready = N'($urandom);
      if ($urandom_range(0, 7) == 0) spur_done = 1'b1;
    end
    @(posedge clk); #1;
    req_valid = '0; rsp_ready = 4'b1111; glitch_en = 1'b0;
    wait_idle("t7_drain_timeout", 200);
    check_eq("t7_progress", n_jobs > j0 + 50, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
